instruction_memory: RTL and testbench
=====================================

Name: instruction_memory

Overview:
- Word-addressed instruction store for the CORG 16-bit processor.
- Sits between the fetch stage PC and decode.
- Read path is asynchronous: the instruction is a combinational function of pc.
- Contents are loaded through a synchronous write port, used by the program loader or the bench.
- Out-of-range fetches return a NOP and raise an error flag.

Parameters:
- DATA_W, 16, instruction width in bits.
- ADDR_W, 16, pc width in bits.
- DEPTH, 256, number of instruction words implemented; must be ≤ 2**ADDR_W.
- NOP_WORD, 16'h0000, value returned for unimplemented addresses and used as the reset fill.

Ports:
- clk  input  1  clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc  input  ADDR_W  word address of the instruction to fetch.
- instruction  output  DATA_W  instruction word at pc.
- addr_err  output  1  high when pc ≥ DEPTH.
- wr_en  input  1  write enable for the load port.
- wr_addr  input  ADDR_W  word address to write.
- wr_data  input  DATA_W  word to write.
- wr_err  output  1  registered flag: high for one cycle after a write attempt with wr_addr ≥ DEPTH.

Behaviour:
- Storage is DEPTH words of DATA_W, indexed by pc[clog2(DEPTH)-1:0] when pc < DEPTH.
- Read is combinational, with zero latency:
  - instruction = mem[pc] when pc < DEPTH, else NOP_WORD.
  - addr_err = (pc ≥ DEPTH).
- Reset (rst_n low, asynchronous assertion):
  - every memory word becomes NOP_WORD.
  - wr_err becomes 0.
  - instruction therefore reads NOP_WORD for any pc while reset is held and after release, until written.
- Writes:
  - On rising clk with rst_n high and wr_en high: if wr_addr < DEPTH, mem[wr_addr] ← wr_data; otherwise the write is dropped and wr_err is 1 in the next cycle.
  - wr_err is 0 on any cycle without a dropped write.
- Read-during-write, same address: instruction shows the old word until the clock edge, then the new word. There is no write-through bypass.
- Reset asserted during a write: reset wins, the write is discarded, and the array fills with NOP_WORD.
- Wrap-around: pc is not wrapped. Addresses DEPTH..2**ADDR_W-1 are out of range and never alias onto low addresses.
- Release of rst_n is synchronised by the system. The block has no reset-release logic.

Optional Feature:
- Macro: INSTR_MEM_PARITY_EN.
- When defined:
  - each stored word carries one extra even-parity bit, computed on write; it is set for NOP_WORD at reset.
  - Extra output port parity_err (1 bit, combinational) is high when the recomputed parity of mem[pc] mismatches the stored bit and pc < DEPTH.
  - instruction is still delivered unchanged.
- When not defined: no parity storage and no parity_err port. All other behaviour is identical.

Decomposition:
- Package instr_mem_pkg holds:
  - DATA_W, ADDR_W and DEPTH defaults.
  - the NOP_WORD constant.
  - a function computing even parity of a DATA_W word.
- No sub-module is needed: a single module with the array, the write process and the combinational read mux.

Test Plan:
- Reset fill: hold rst_n=0, sweep pc 0..255 with 100 ns per step → instruction=16'h0000 and addr_err=0 at every pc.
- Load and readback: write mem[k] = 16'hA500 | k for k=0..255, then sweep pc 0..255 → instruction equals 16'hA500|k, and results are printed as "Instruction at PC k".
- Out of range:
  - pc=256 and pc=16'hFFFF → instruction=16'h0000, addr_err=1.
  - Write to wr_addr=300 → mem unchanged (mem[44] still intact) and wr_err=1 for exactly one cycle.
- Read-during-write: pc=5 with mem[5]=16'h1111; write 16'h2222 to address 5 → instruction stays 16'h1111 before the edge and becomes 16'h2222 after it.
- Async reset mid-operation: after loading, pull rst_n low between clock edges with wr_en=1 → instruction=16'h0000 immediately, before the next clk edge, and the pending write is not applied.
- With INSTR_MEM_PARITY_EN: write 16'h0001 to address 3 and force-flip its stored parity bit → parity_err=1 at pc=3, parity_err=0 at other pcs.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared defaults, NOP constant and parity helper for the instruction memory
package instr_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 256;

  localparam logic [DATA_W_DEF-1:0] NOP_WORD_DEF = 16'h0000;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W_DEF-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - CORG16 instruction store: async read, sync load port; INSTR_MEM_PARITY_EN adds parity_err
module instruction_memory
  import instr_mem_pkg::*;
#(
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter int                 ADDR_W   = ADDR_W_DEF,
  parameter int                 DEPTH    = DEPTH_DEF,
  parameter logic [DATA_W-1:0]  NOP_WORD = NOP_WORD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic              addr_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef INSTR_MEM_PARITY_EN
  output logic              parity_err,
`endif
  output logic              wr_err
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_err_q;
  logic              wr_err_d;
  logic              pc_in_range;
  logic              wr_in_range;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;

  // Full-width compare so high addresses never alias onto the low words.
  assign pc_in_range = {1'b0, pc} < DEPTH_CMP;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_CMP;
  assign rd_idx      = pc[IDX_W-1:0];
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign wr_err_d    = wr_en && !wr_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP_WORD;
      end
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
      if (wr_en && wr_in_range) begin
        mem_q[wr_idx] <= wr_data;
      end
    end
  end

  always_comb begin
    instruction = NOP_WORD;
    if (pc_in_range) begin
      instruction = mem_q[rd_idx];
    end
  end

  assign addr_err = !pc_in_range;
  assign wr_err   = wr_err_q;

`ifdef INSTR_MEM_PARITY_EN
  logic [DEPTH-1:0] par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= {DEPTH{even_parity(NOP_WORD)}};
    end else if (wr_en && wr_in_range) begin
      par_q[wr_idx] <= even_parity(wr_data);
    end
  end

  assign parity_err = pc_in_range && (even_parity(mem_q[rd_idx]) != par_q[rd_idx]);
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - directed scoreboard bench for instruction_memory
module tb_instruction_memory;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        addr_err;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_err;
`ifdef INSTR_MEM_PARITY_EN
  logic        parity_err;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] instr;
    logic        aerr;
  } exp_t;

  exp_t sb_q[$];

  instruction_memory dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .instruction (instruction),
    .addr_err    (addr_err),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
`ifdef INSTR_MEM_PARITY_EN
    .parity_err  (parity_err),
`endif
    .wr_err      (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_pc(input logic [15:0] addr, input logic [15:0] exp_instr, input logic exp_aerr);
    exp_t e;
    pc      = addr;
    e.instr = exp_instr;
    e.aerr  = exp_aerr;
    sb_q.push_back(e);
  endtask

  task automatic check_read(input string tag);
    exp_t e;
    #1;
    checks++;
    assert (sb_q.size() > 0) else begin
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      assert (instruction === e.instr) else begin
        failures++;
        $error("FAIL %s.instruction pc=%h observed=%h expected=%h", tag, pc, instruction, e.instr);
      end
      checks++;
      assert (addr_err === e.aerr) else begin
        failures++;
        $error("FAIL %s.addr_err pc=%h observed=%b expected=%b", tag, pc, addr_err, e.aerr);
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic write_word(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    pc      = 16'h0000;
    wr_en   = 1'b0;
    wr_addr = 16'h0000;
    wr_data = 16'h0000;

    // Reset fill, held in reset.
    for (int k = 0; k < 256; k++) begin
      drive_pc(16'(k), 16'h0000, 1'b0);
      #99;
      check_read("reset_fill");
    end
    check_bit("reset_wr_err", wr_err, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 256; k++) begin
      write_word(16'(k), 16'hA500 | 16'(k));
    end
    for (int k = 0; k < 256; k++) begin
      drive_pc(16'(k), 16'hA500 | 16'(k), 1'b0);
      check_read("readback");
      $display("Instruction at PC %0d = %h", k, instruction);
    end

    drive_pc(16'd256, 16'h0000, 1'b1);
    check_read("oor_256");
    drive_pc(16'hFFFF, 16'h0000, 1'b1);
    check_read("oor_ffff");
    drive_pc(16'h0100 | 16'd44, 16'h0000, 1'b1);
    check_read("no_alias_300");

    // Dropped write: flag lasts exactly one cycle.
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 16'd300;
    wr_data = 16'hDEAD;
    #1;
    check_bit("wr_err_before_edge", wr_err, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    check_bit("wr_err_pulse", wr_err, 1'b1);
    @(negedge clk);
    check_bit("wr_err_cleared", wr_err, 1'b0);
    drive_pc(16'd44, 16'hA52C, 1'b0);
    check_read("mem44_intact");

    // Read-during-write on the same address.
    write_word(16'd5, 16'h1111);
    @(negedge clk);
    drive_pc(16'd5, 16'h1111, 1'b0);
    wr_en   = 1'b1;
    wr_addr = 16'd5;
    wr_data = 16'h2222;
    check_read("rdw_old");
    @(posedge clk);
    sb_q.push_back('{instr: 16'h2222, aerr: 1'b0});
    check_read("rdw_new");
    @(negedge clk);
    wr_en = 1'b0;

    // Async reset between edges with a write pending.
    @(negedge clk);
    drive_pc(16'd7, 16'hA507, 1'b0);
    wr_en   = 1'b1;
    wr_addr = 16'd10;
    wr_data = 16'hBEEF;
    check_read("pre_reset");
    #1;
    rst_n = 1'b0;
    sb_q.push_back('{instr: 16'h0000, aerr: 1'b0});
    check_read("async_reset_now");
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_pc(16'd10, 16'h0000, 1'b0);
    check_read("pending_write_dropped");
    drive_pc(16'd255, 16'h0000, 1'b0);
    check_read("post_reset_fill");
    check_bit("post_reset_wr_err", wr_err, 1'b0);

`ifdef INSTR_MEM_PARITY_EN
    write_word(16'd3, 16'h0001);
    pc = 16'd3;
    #1;
    check_bit("parity_clean", parity_err, 1'b0);
    force dut.par_q[3] = 1'b0;
    #1;
    check_bit("parity_flip_pc3", parity_err, 1'b1);
    pc = 16'd4;
    #1;
    check_bit("parity_pc4", parity_err, 1'b0);
    pc = 16'd256;
    #1;
    check_bit("parity_oor", parity_err, 1'b0);
    release dut.par_q[3];
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
